// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA types plus the fetch-side additions: FSM encoding, queue entry, reset PC.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int    FETCH_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_IDLE  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits of a target are dropped.
  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Bundle of the fetch PC unit's signals: redirect input, imem handshake and decode-side queue head.
interface fetch_pc_if
  import rv32ima_pkg::*;
(
  input logic clk
);

  logic  rst;
  logic  next_addr_en;
  word_t next_addr;
  logic  stall;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;
  logic  inst_valid;
  word_t inst;
  word_t inst_pc;

  modport fpu (
    input  clk, rst, next_addr_en, next_addr, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport tb (
    input  clk, imem_req, imem_addr, inst_valid, inst, inst_pc,
    output rst, next_addr_en, next_addr, stall, imem_ack, imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue; slot 0 is always the head. flush beats push and pop.
module fetch_buffer
  import rv32ima_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot_reg  [DEPTH];
  fetch_entry_t slot_next [DEPTH];
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         pop_ok;

  assign pop_ok = pop && (count_reg != 2'd0);

  always_comb begin
    slot_next  = slot_reg;
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && pop_ok) begin
      // Simultaneous push/pop keeps occupancy; the new entry lands behind any survivor.
      if (count_reg == 2'(DEPTH)) begin
        slot_next[0] = slot_reg[1];
        slot_next[1] = wr_entry;
      end else begin
        slot_next[0] = wr_entry;
      end
    end else if (push) begin
      if (count_reg == 2'd0) begin
        slot_next[0] = wr_entry;
      end else begin
        slot_next[1] = wr_entry;
      end
      count_next = count_reg + 2'd1;
    end else if (pop_ok) begin
      slot_next[0] = slot_reg[1];
      count_next   = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= slot_next[i];
      end
    end
  end

  assign head  = slot_reg[0];
  assign count = count_reg;

  // Requests are only issued with a free slot reserved, so a push can never overflow.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop_ok && (count_reg == 2'(DEPTH))));

endmodule

// File: rtl/fetch_pc_unit.sv
// Owns the fetch PC, drives the imem req/ack handshake and applies branch-resolver redirects.
module fetch_pc_unit
  import rv32ima_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEFAULT,
  parameter int    BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  next_addr_en,
  input  word_t next_addr,
  input  logic  stall,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ack,
  input  word_t imem_rdata,
  output logic  inst_valid,
  output word_t inst,
  output word_t inst_pc
);

  localparam logic [1:0] ST_FETCH = S_FETCH;
  localparam logic [1:0] ST_DROP  = S_DROP;
  localparam logic [1:0] ST_IDLE  = S_IDLE;

  logic [1:0]   state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        pend_pc_reg, pend_pc_next;
  word_t        redirect_pc;
  word_t        pc_inc;
  logic         ack_seen;
  logic         buf_valid;
  logic         push, pop, flush;
  logic [1:0]   count;
  logic [1:0]   fill_after;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  assign redirect_pc = align_word(next_addr);
  assign pc_inc      = pc_reg + 32'd4;

  // imem shares rst, so no request is presented while reset is held.
  assign imem_req  = !rst && (state_reg != ST_IDLE);
  assign imem_addr = pc_reg;
  assign ack_seen  = imem_ack && imem_req;

  assign buf_valid = (count != 2'd0);
  assign pop       = buf_valid && !stall && !next_addr_en;
  assign flush     = next_addr_en;
  assign push      = (state_reg == ST_FETCH) && ack_seen && !next_addr_en;
  assign wr_entry  = '{inst: imem_rdata, pc: pc_reg};
  assign fill_after = pop ? count : count + 2'd1;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pend_pc_next = pend_pc_reg;
    case (state_reg)
      ST_FETCH: begin
        if (ack_seen) begin
          if (next_addr_en) begin
            pc_next = redirect_pc;
          end else begin
            pc_next = pc_inc;
            if (fill_after == 2'(BUF_DEPTH)) begin
              state_next = ST_IDLE;
            end
          end
        end else if (next_addr_en) begin
          // Request is still outstanding: keep it stable and drop its response later.
          pend_pc_next = redirect_pc;
          state_next   = ST_DROP;
        end
      end
      ST_DROP: begin
        if (ack_seen) begin
          pc_next    = next_addr_en ? redirect_pc : pend_pc_reg;
          state_next = ST_FETCH;
        end else if (next_addr_en) begin
          pend_pc_next = redirect_pc;
        end
      end
      ST_IDLE: begin
        if (next_addr_en) begin
          pc_next    = redirect_pc;
          state_next = ST_FETCH;
        end else if (pop) begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= align_word(RESET_PC);
      pend_pc_reg <= align_word(RESET_PC);
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pend_pc_reg <= pend_pc_next;
    end
  end

  assign inst_valid = buf_valid;
  assign inst       = buf_valid ? head.inst : '0;
  assign inst_pc    = buf_valid ? head.pc : '0;

endmodule
